fifo_wr_packer: RTL and testbench
=================================

Name: fifo_wr_packer

Overview:
- Producer-side counterpart to the first-word-fall-through read adapter.
- Accepts a narrow valid/ready beat stream and packs RATIO beats into one wide FIFO word.
- Drives the FIFO's WR_ENB/FULL write port, with a one-word output register so FIFO backpressure never drops data.
- Sits in front of cache refill/writeback FIFOs, where narrow bus beats become cache-line-width entries.

Parameters:
- IN_WIDTH, 8, width of one input beat.
- RATIO, 4, input beats per FIFO word; must be at least 1.
- OUT_WIDTH, IN_WIDTH*RATIO, FIFO word width; derived, do not override.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- S_VALID  in  1  input beat valid.
- S_READY  out  1  block accepts a beat this cycle.
- S_DATA  in  IN_WIDTH  input beat.
- S_LAST  in  1  final beat of a burst; closes the word early.
- FIFO_WR_ENB  out  1  write strobe to the FIFO.
- FIFO_DATA  out  OUT_WIDTH  packed word.
- FIFO_MASK  out  RATIO  per-lane valid bits of FIFO_DATA.
- FIFO_FULL  in  1  FIFO full flag.

Behaviour:
- State:
  - pack register (OUT_WIDTH) with lane counter lane_cnt (0..RATIO-1);
  - pack mask (RATIO);
  - output register out_data/out_mask with flag out_valid.
- Reset (RST=1 at an edge):
  - lane_cnt=0, pack and out registers and masks cleared to 0, out_valid=0;
  - FIFO_WR_ENB is gated by !RST, so it is 0 during any reset cycle;
  - S_READY is gated by !RST, so it is 0 during reset.
  - Reset mid-burst discards the partial word and any pending output word; nothing reaches the FIFO.
- Outputs:
  - FIFO_DATA=out_data and FIFO_MASK=out_mask at all times.
  - FIFO_WR_ENB = out_valid & !FIFO_FULL & !RST (combinational).
- Handshake:
  - S_READY = !RST & (!out_valid | !FIFO_FULL), combinational.
  - A beat is accepted when S_VALID & S_READY.
  - Sustained throughput is one beat per cycle while the FIFO is not full.
- Lane placement:
  - an accepted beat is written to lane lane_cnt, i.e. bits [lane_cnt*IN_WIDTH +: IN_WIDTH];
  - the first beat goes to lane 0 (little-endian);
  - the corresponding pack mask bit is set.
- Word close: the word closes when the accepted beat has lane_cnt==RATIO-1 or S_LAST=1. On close, in the same edge:
  - out_data = pack with the current beat merged in;
  - out_mask = accumulated mask plus the current lane bit;
  - unfilled lanes read 0 with mask bit 0;
  - out_valid=1;
  - pack register and mask cleared, lane_cnt=0.
- Non-closing beat: lane_cnt increments; out register unaffected.
- Write completion: when FIFO_WR_ENB=1 and no word closes in the same cycle, out_valid=0 next cycle. A close and a write in the same cycle leave out_valid=1 holding the new word (back-to-back, no bubble).
- Latency:
  - closing beat accepted at edge N → FIFO_WR_ENB high in cycle N+1 if FIFO_FULL=0;
  - otherwise held, stable, until FULL deasserts.
- Backpressure: while out_valid & FIFO_FULL, S_READY=0 and the pack register is frozen. This holds even for non-closing beats, which keeps the ready logic simple.
- S_LAST with lane_cnt==0 produces a one-lane word with mask 0...01.
- RATIO=1: every accepted beat closes a word; the block acts as a registered single-entry write buffer with mask always 1.
- S_VALID without S_READY: no state change. The producer must hold S_DATA/S_LAST stable (standard valid/ready rule).

Decomposition:
- Shared cache package holds:
  - the lane-index width constant, $clog2(RATIO) with a minimum of 1;
  - a function computing the one-hot lane mask from the lane index.
- Sub-module: none required. The output register plus FULL gating is small enough to stay inline.
- Instantiate alongside FIFO (write side) and FIFO_FWFT (read side) in cache buffer wrappers.

Test Plan (IN_WIDTH=8, RATIO=4):
- Reset then S_VALID with beats 0x11,0x22,0x33,0x44 on consecutive cycles, FIFO_FULL=0 → exactly one FIFO_WR_ENB pulse, the cycle after 0x44; FIFO_DATA=0x44332211, FIFO_MASK=4'b1111.
- 0xAA then 0xBB with S_LAST=1 → FIFO_DATA=0x0000BBAA, MASK=4'b0011; the next four beats start again at lane 0.
- 8 back-to-back beats 0x01..0x08, FULL=0 → S_READY constantly 1; writes 0x04030201 then 0x08070605, with no bubble between words.
- FULL=1 when the first word completes → FIFO_WR_ENB=0 and S_READY=0, FIFO_DATA held at 0x04030201; drop FULL after 5 cycles → single write, S_READY returns to 1 in the same cycle.
- Beats 0x11,0x22 accepted, RST pulsed one cycle, then 0x33,0x44,0x55,0x66 → no write of the partial word; next write is 0x66554433, MASK=4'b1111.
- Lone beat 0x7E with S_LAST at lane 0 → FIFO_DATA=0x0000007E, MASK=4'b0001, one write.

Source files
------------

// File: rtl/fifo_wr_packer_pkg.sv
// Shared constants and helpers for the narrow-to-wide FIFO write packer.
package fifo_wr_packer_pkg;

  // Widest lane mask the helper below can produce; callers truncate to RATIO.
  localparam int MAX_LANES = 64;

  // Width of a lane index for a given ratio, never less than one bit.
  function automatic int lane_idx_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // One-hot lane mask for lane index idx (bit idx set).
  function automatic logic [MAX_LANES-1:0] lane_onehot(input int unsigned idx);
    return {{(MAX_LANES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs RATIO narrow valid/ready beats into one wide FIFO word with a lane
// mask. A single output register holds the closed word until the FIFO accepts
// it, so FIFO_FULL never causes data loss.
module fifo_wr_packer
  import fifo_wr_packer_pkg::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic [IN_WIDTH-1:0]  S_DATA,
  input  logic                 S_LAST,
  output logic                 FIFO_WR_ENB,
  output logic [OUT_WIDTH-1:0] FIFO_DATA,
  output logic [RATIO-1:0]     FIFO_MASK,
  input  logic                 FIFO_FULL
);

  localparam int LW = lane_idx_w(RATIO);

  logic [LW-1:0]        lane_cnt;
  logic [OUT_WIDTH-1:0] pack_data;
  logic [RATIO-1:0]     pack_mask;
  logic [OUT_WIDTH-1:0] out_data;
  logic [RATIO-1:0]     out_mask;
  logic                 out_valid;

  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     lane_bit;
  logic                 accept;
  logic                 close;

  // Handshake and write strobe; both forced low while reset is asserted.
  assign S_READY     = ~RST & (~out_valid | ~FIFO_FULL);
  assign FIFO_WR_ENB = out_valid & ~FIFO_FULL & ~RST;
  assign FIFO_DATA   = out_data;
  assign FIFO_MASK   = out_mask;

  assign accept = S_VALID & S_READY;
  assign close  = accept & ((lane_cnt == LW'(RATIO - 1)) | S_LAST);

  // Current pack contents with the incoming beat dropped into its lane.
  always_comb begin
    merged_data = pack_data;
    merged_data[int'(lane_cnt) * IN_WIDTH +: IN_WIDTH] = S_DATA;
    lane_bit = RATIO'(lane_onehot(32'(lane_cnt)));
  end

  // Pack accumulation, word close into the output register, write retirement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lane_cnt  <= '0;
      pack_data <= '0;
      pack_mask <= '0;
      out_data  <= '0;
      out_mask  <= '0;
      out_valid <= 1'b0;
    end else begin
      // A write frees the output register unless a new word lands this edge.
      if (FIFO_WR_ENB) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (close) begin
          out_data  <= merged_data;
          out_mask  <= pack_mask | lane_bit;
          out_valid <= 1'b1;
          pack_data <= '0;
          pack_mask <= '0;
          lane_cnt  <= '0;
        end else begin
          pack_data <= merged_data;
          pack_mask <= pack_mask | lane_bit;
          lane_cnt  <= lane_cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Bench for fifo_wr_packer (IN_WIDTH=8, RATIO=4): directed scenarios plus a
// randomized run, all checked against a queue-based word-assembly model.
module tb_fifo_wr_packer;

  localparam int IN_WIDTH  = 8;
  localparam int RATIO     = 4;
  localparam int OUT_WIDTH = IN_WIDTH * RATIO;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 S_VALID;
  logic                 S_READY;
  logic [IN_WIDTH-1:0]  S_DATA;
  logic                 S_LAST;
  logic                 FIFO_WR_ENB;
  logic [OUT_WIDTH-1:0] FIFO_DATA;
  logic [RATIO-1:0]     FIFO_MASK;
  logic                 FIFO_FULL;

  fifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .CLK(CLK), .RST(RST),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .FIFO_WR_ENB(FIFO_WR_ENB), .FIFO_DATA(FIFO_DATA), .FIFO_MASK(FIFO_MASK),
    .FIFO_FULL(FIFO_FULL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: beats collected for the word being built, and the one
  // completed word waiting for the FIFO.
  logic [7:0]  part_q[$];
  bit          pend = 1'b0;
  logic [31:0] pend_data = '0;
  logic [3:0]  pend_mask = '0;

  // Words the DUT actually wrote, for the directed expectations.
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_mask_q[$];
  int          ready_lows;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, update model at the edge.
  task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit last, input bit full);
    bit exp_rdy, exp_wr, acc;
    RST = rst; S_VALID = v; S_DATA = d; S_LAST = last; FIFO_FULL = full;
    @(negedge CLK);
    exp_rdy = !rst && (!pend || !full);
    exp_wr  = pend && !full && !rst;
    chk("s_ready", 32'(S_READY), 32'(exp_rdy));
    chk("fifo_wr_enb", 32'(FIFO_WR_ENB), 32'(exp_wr));
    if (pend && !rst) begin
      chk("fifo_data", FIFO_DATA, pend_data);
      chk("fifo_mask", 32'(FIFO_MASK), 32'(pend_mask));
    end
    if (!S_READY) ready_lows++;
    if (FIFO_WR_ENB) begin
      wr_data_q.push_back(FIFO_DATA);
      wr_mask_q.push_back(FIFO_MASK);
    end
    @(posedge CLK);
    if (rst) begin
      part_q.delete();
      pend = 1'b0;
    end else begin
      acc = v && exp_rdy;
      if (exp_wr) pend = 1'b0;
      if (acc) begin
        part_q.push_back(d);
        if (last || part_q.size() == RATIO) begin
          pend_data = '0;
          pend_mask = '0;
          foreach (part_q[i]) begin
            pend_data = pend_data | (32'(part_q[i]) << (8 * i));
            pend_mask[i] = 1'b1;
          end
          pend = 1'b1;
          part_q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    wr_data_q.delete();
    wr_mask_q.delete();
    ready_lows = 0;
  endtask

  initial begin
    RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; S_LAST = 1'b0; FIFO_FULL = 1'b0;
    ready_lows = 0;

    // Reset state
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    idle(1);
    chk("reset_data", FIFO_DATA, 32'h0);
    chk("reset_mask", 32'(FIFO_MASK), 32'h0);

    // Full word of four beats
    clear_log();
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    idle(2);
    chk("t1_count", 32'(wr_data_q.size()), 32'd1);
    chk("t1_data", wr_data_q[0], 32'h44332211);
    chk("t1_mask", 32'(wr_mask_q[0]), 32'hF);

    // Early close with S_LAST, then a full word from lane 0
    clear_log();
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hBB, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h88, 1'b0, 1'b0);
    idle(2);
    chk("t2_count", 32'(wr_data_q.size()), 32'd2);
    chk("t2_data0", wr_data_q[0], 32'h0000BBAA);
    chk("t2_mask0", 32'(wr_mask_q[0]), 32'h3);
    chk("t2_data1", wr_data_q[1], 32'h88776655);

    // Eight back-to-back beats
    clear_log();
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("t3_ready_lows", 32'(ready_lows), 32'd0);
    idle(2);
    chk("t3_count", 32'(wr_data_q.size()), 32'd2);
    chk("t3_data0", wr_data_q[0], 32'h04030201);
    chk("t3_data1", wr_data_q[1], 32'h08070605);

    // FIFO full as the first word completes
    clear_log();
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h05, 1'b0, 1'b1);
    chk("t4_ready_lows", 32'(ready_lows), 32'd5);
    chk("t4_no_write", 32'(wr_data_q.size()), 32'd0);
    chk("t4_held_data", FIFO_DATA, 32'h04030201);
    for (int i = 5; i <= 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    idle(2);
    chk("t4_count", 32'(wr_data_q.size()), 32'd2);
    chk("t4_data0", wr_data_q[0], 32'h04030201);
    chk("t4_data1", wr_data_q[1], 32'h08070605);

    // Reset mid-burst discards the partial word
    clear_log();
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h44, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b0, 1'b0);
    idle(2);
    chk("t5_count", 32'(wr_data_q.size()), 32'd1);
    chk("t5_data", wr_data_q[0], 32'h66554433);
    chk("t5_mask", 32'(wr_mask_q[0]), 32'hF);

    // Lone beat with S_LAST at lane 0
    clear_log();
    step(1'b0, 1'b1, 8'h7E, 1'b1, 1'b0);
    idle(2);
    chk("t6_count", 32'(wr_data_q.size()), 32'd1);
    chk("t6_data", wr_data_q[0], 32'h0000007E);
    chk("t6_mask", 32'(wr_mask_q[0]), 32'h1);

    // Randomized traffic; inputs held while a beat is stalled
    begin
      bit v, l, f, r;
      logic [7:0] d;
      v = 1'b0; l = 1'b0; d = '0;
      for (int i = 0; i < 400; i++) begin
        if (!v || S_READY) begin
          v = ($urandom_range(0, 3) != 0);
          d = 8'($urandom);
          l = ($urandom_range(0, 4) == 0);
        end
        f = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 60) == 0);
        step(r, v, d, l, f);
        if (r) v = 1'b0;
      end
      idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
